// File: rtl/router_pkg.sv
// router_pkg: flit geometry and arbitration-mode encodings shared by the
// collective router's reduction path.
package router_pkg;

  localparam int VALID_BIT_POS = 81;
  localparam int LG_NUMPROCS   = 3;
  localparam int FLIT_W        = VALID_BIT_POS + 1;
  localparam int FLIT_CHILD_W  = FLIT_W + LG_NUMPROCS;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Adds step to base and folds the result back into [0, modulus).
  // Callers only ever pass base and step below modulus, so one subtraction is enough.
  function automatic int wrap_add(input int base, input int step, input int modulus);
    int sum;
    sum = base + step;
    if (sum >= modulus) begin
      return sum - modulus;
    end else begin
      return sum;
    end
  endfunction

endpackage

// File: rtl/reduction_tree_rr_if.sv
// reduction_tree_rr_if: child-flit request bus plus the registered output
// handshake of the merge stage. The slave modport is the merge stage itself.
interface reduction_tree_rr_if
  import router_pkg::*;
#(
  parameter int FAN_IN = 6,
  parameter int SEL_W  = $clog2(FAN_IN)
);

  logic [FLIT_CHILD_W*FAN_IN-1:0] in_data;
  logic [FAN_IN-1:0]              in_valid;
  logic [FAN_IN-1:0]              in_avail;
  logic [FLIT_CHILD_W-1:0]        out_data;
  logic                           out_valid;
  logic                           out_ready;
  logic [SEL_W-1:0]               grant_idx;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_avail, out_data, out_valid, grant_idx
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_avail, out_data, out_valid, grant_idx
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks one requesting port per cycle, either lowest index first
// or round-robin from a rotating pointer. The pointer only moves on a grant.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int FAN_IN   = 6,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = $clog2(FAN_IN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FAN_IN-1:0] req,
  input  logic              advance,
  output logic [FAN_IN-1:0] grant_onehot,
  output logic [SEL_W-1:0]  grant_idx
);

  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] ptr_d;
  logic [SEL_W-1:0] pick_s;
  logic             found_s;
  int               start_s;
  int               cand_s;

  // Fixed priority is a round-robin search that always starts at port 0.
  assign start_s = (ARB_MODE == ARB_RR) ? int'(ptr_q) : 0;
  assign found_s = |req;

  // Circular scan from start_s; walking backwards lets the nearest requester win.
  always_comb begin
    pick_s = '0;
    cand_s = 0;
    for (int k = FAN_IN - 1; k >= 0; k--) begin
      cand_s = wrap_add(start_s, k, FAN_IN);
      pick_s = req[cand_s] ? SEL_W'(cand_s) : pick_s;
    end
  end

  // A grant is only issued when the output stage can take the flit.
  always_comb begin
    grant_onehot = '0;
    if (advance && found_s) begin
      grant_onehot = FAN_IN'(1) << pick_s;
    end else begin
      grant_onehot = '0;
    end
  end

  assign grant_idx = pick_s;

  // Pointer moves past the granted port; it stays put on idle or stalled cycles.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_s) begin
      ptr_d = SEL_W'(wrap_add(int'(pick_s), 1, FAN_IN));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/reduction_tree_rr.sv
// reduction_tree_rr: N-input child-flit merge stage. Each cycle one valid
// child flit is popped into a single registered output slot with
// valid/ready backpressure. A pop and a load can happen in the same cycle.
module reduction_tree_rr
  import router_pkg::*;
#(
  parameter int FAN_IN   = 6,
  parameter int ARB_MODE = ARB_RR,
  localparam int SEL_W   = $clog2(FAN_IN)
) (
  input  logic                  clk,
  input  logic                  rst,
  reduction_tree_rr_if.slave    bus
);

  logic [FLIT_CHILD_W-1:0] out_q;
  logic [FLIT_CHILD_W-1:0] out_d;
  logic                    out_valid_q;
  logic                    out_valid_d;
  logic [SEL_W-1:0]        grant_idx_q;
  logic [SEL_W-1:0]        grant_idx_d;

  logic                    can_load_s;
  logic                    advance_s;
  logic                    load_s;
  logic [FAN_IN-1:0]       grant_onehot_s;
  logic [SEL_W-1:0]        grant_sel_s;
  logic [FLIT_CHILD_W-1:0] sel_flit_s;

  // The slot can take a flit when it is empty or being emptied this cycle.
  // Reset masks every grant, so nothing is popped while rst is high.
  assign can_load_s = !out_valid_q || bus.out_ready;
  assign advance_s  = can_load_s && !rst;

  rr_arbiter #(
    .FAN_IN   (FAN_IN),
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.in_valid),
    .advance      (advance_s),
    .grant_onehot (grant_onehot_s),
    .grant_idx    (grant_sel_s)
  );

  assign load_s     = |grant_onehot_s;
  assign sel_flit_s = bus.in_data[int'(grant_sel_s)*FLIT_CHILD_W +: FLIT_CHILD_W];

  // Load a granted flit, otherwise clear the slot when its flit is accepted.
  // Under backpressure the slot holds.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    grant_idx_d = grant_idx_q;
    if (load_s) begin
      out_d       = sel_flit_s;
      out_valid_d = 1'b1;
      grant_idx_d = grant_sel_s;
    end else if (out_valid_q && bus.out_ready) begin
      out_d       = '0;
      out_valid_d = 1'b0;
      grant_idx_d = grant_idx_q;
    end else begin
      out_d       = out_q;
      out_valid_d = out_valid_q;
      grant_idx_d = grant_idx_q;
    end
  end

  // Output slot register. Reset discards any flit that is being held.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      grant_idx_q <= '0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign bus.in_avail  = grant_onehot_s;
  assign bus.out_data  = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.grant_idx = grant_idx_q;

endmodule

// File: doc/reduction_tree_rr.md
Name: reduction_tree_rr

Overview:
- Parametrised N-input flit merge stage for the collective router's reduction path.
- Selects one valid child flit per cycle and holds it in a registered output stage with valid/ready backpressure.
- Arbitration is fixed-priority (legacy-compatible ordering) or round-robin (fair).
- Sits between the per-port input buffers and the reduction/combine datapath, replacing the combinational 6-port selector.

Parameters:
- FAN_IN, 6, number of input ports (2..16).
- VALID_BIT_POS, 81, bit index of the valid flag inside a flit.
- LG_NUMPROCS, 3, width of the children field appended to each flit.
- FLIT_W, VALID_BIT_POS+1, flit width (derived).
- FLIT_CHILD_W, FLIT_W+LG_NUMPROCS, per-port payload width (derived).
- ARB_MODE, 1, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- SEL_W, $clog2(FAN_IN), grant index width (derived).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- in  in  FLIT_CHILD_W*FAN_IN  packed child flits; port i occupies [i*FLIT_CHILD_W +: FLIT_CHILD_W].
- in_valid  in  FAN_IN  per-port flit present.
- in_avail  out  FAN_IN  pop strobe; one-hot or zero; port i's flit is consumed this cycle.
- out  out  FLIT_CHILD_W  registered selected flit.
- out_valid  out  1  out holds a flit.
- out_ready  in  1  downstream accepts out this cycle.
- grant_idx  out  SEL_W  registered source port of the flit currently in out (debug/stats).

Behaviour:
- Reset (rst high at a clock edge):
  - out = 0, out_valid = 0, grant_idx = 0, round-robin pointer = 0.
  - While rst is high, in_avail = 0 combinationally and nothing is accepted.
  - A flit held in out when reset hits is discarded.
- Output stage:
  - Single register. can_load = !out_valid || out_ready.
  - Latency from acceptance to out_valid is exactly 1 cycle.
  - Sustained throughput is 1 flit/cycle while out_ready = 1.
- Arbitration (combinational, every cycle):
  - Request vector req = in_valid.
  - If req == 0 or !can_load: in_avail = 0 and the register holds (or clears, see below).
  - Otherwise exactly one bit of in_avail is set, the grant g.
  - At that edge: out <= in[g]; out_valid <= 1; grant_idx <= g.
- Fixed-priority mode (ARB_MODE=0): g = lowest index with req set.
- Round-robin mode (ARB_MODE=1):
  - Search starts at ptr and wraps modulo FAN_IN; g = first set bit at or after ptr.
  - On each grant, ptr <= (g+1) mod FAN_IN; wrap from FAN_IN-1 goes to 0.
  - ptr does not move when there is no grant.
- Drain: if out_valid && out_ready && no grant this cycle, out_valid <= 0 and out <= 0.
- Backpressure: if out_valid && !out_ready, then out, out_valid and grant_idx hold, in_avail = 0, and ptr holds.
- Simultaneous pop and load: when out_ready = 1 and a request exists, the new flit replaces the old one in the same edge with no bubble.
- Input contract: an input must keep its flit and in_valid stable until it sees in_avail. A port may drop in_valid without being granted; no state is affected.
- in_avail is never asserted for a port whose in_valid = 0.

Decomposition:
- Shared package `router_pkg` holds VALID_BIT_POS, LG_NUMPROCS, FLIT_W and FLIT_CHILD_W, plus the ARB_MODE encodings ARB_FIXED = 0 and ARB_RR = 1.
- Sub-module `rr_arbiter`:
  - Parameters FAN_IN and ARB_MODE.
  - Inputs clk, rst, req, advance; outputs grant_onehot and grant_idx.
  - Contains the pointer register.
  - Top level owns the output register and the payload mux.

Test Plan:
- Reset mid-stream: out_valid = 1 holding port 2, assert rst one cycle -> next cycle out_valid = 0, out = 0, in_avail = 0 during rst, ptr = 0 (verified by the next grant order).
- Round-robin fairness: FAN_IN = 6, in_valid = 6'b111111 held, out_ready = 1 -> grant_idx sequence 0,1,2,3,4,5,0,... with one flit per cycle and each in_avail one-hot.
- Fixed priority: ARB_MODE = 0, in_valid = 6'b101100 -> grants 2 while its valid stays high; when port 2 drops valid -> grants 3; port 0 never starves port 5 check not applicable.
- Backpressure: load port 4 (flit 0x..AB), out_ready = 0 for 3 cycles with in_valid = 6'b000011 -> out stays 0x..AB, in_avail = 0, ptr unchanged; raising out_ready -> port 0 loaded the same edge and out_valid stays 1.
- Wrap and sparse requests: ptr = 5, in_valid = 6'b000010 -> grant 1, ptr becomes 2; next in_valid = 6'b000001 -> grant 0.
- Drain: a single flit, then in_valid = 0 with out_ready = 1 -> out_valid is 1 for exactly one cycle, then 0, and out = 0.
